id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS pipeline, with integrated load-use hazard detection.
- Captures decoded controls, operands and register specifiers from ID each cycle.
- Its Rs/Rt/controls drive the EX-stage operand-forwarding logic and ALU.
- Detects load-use hazards: freezes PC and IF/ID, and inserts a bubble.
- Squashes the ID instruction on a branch/jump flush.
- Keeps a saturating count of inserted bubbles for performance debug.

---
 rtl/id_ex_stage_reg.sv | 90 +++++++++
 tb/tb_id_ex_stage_reg.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use stall detection, flush bubbles and a saturating bubble counter
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemtoReg,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic [1:0]        ID_ALUOp,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_SignExt,
    input  logic [REG_W-1:0]  ID_Rs,
    input  logic [REG_W-1:0]  ID_Rt,
    input  logic [REG_W-1:0]  ID_Rd,
    input  logic              ID_Flush,
    output logic              ID_Ex_RegWrite,
    output logic              ID_Ex_MemRead,
    output logic              ID_Ex_MemWrite,
    output logic              ID_Ex_MemtoReg,
    output logic              ID_Ex_ALUSrc,
    output logic              ID_Ex_RegDst,
    output logic [1:0]        ID_Ex_ALUOp,
    output logic [DATA_W-1:0] ID_Ex_ReadData1,
    output logic [DATA_W-1:0] ID_Ex_ReadData2,
    output logic [DATA_W-1:0] ID_Ex_SignExt,
    output logic [REG_W-1:0]  ID_Ex_Rs,
    output logic [REG_W-1:0]  ID_Ex_Rt,
    output logic [REG_W-1:0]  ID_Ex_Rd,
    output logic              PCWrite,
    output logic              IF_IDWrite,
    output logic              Stall,
    output logic [CNT_W-1:0]  BubbleCount
);
    logic [7:0]        r_ctrl;
    logic [DATA_W-1:0] r_rd1, r_rd2, r_se;
    logic [REG_W-1:0]  r_rs, r_rt, r_rd;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_hz, w_bubble;

    assign w_hz = r_ctrl[6] && (r_rt != '0) &&
                  ((ID_UsesRs && r_rt == ID_Rs) || (ID_UsesRt && r_rt == ID_Rt));
    assign Stall      = w_hz & ~ID_Flush & ~reset;
    assign PCWrite    = ~Stall;
    assign IF_IDWrite = ~Stall;
    assign w_bubble   = Stall | ID_Flush;

    // Bubbles zero the specifiers too, so forwarding compares never match a squashed slot
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_ctrl <= '0;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_se   <= '0;
            r_rs   <= '0;
            r_rt   <= '0;
            r_rd   <= '0;
        end else begin
            r_ctrl <= {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst, ID_ALUOp};
            r_rd1  <= ID_ReadData1;
            r_rd2  <= ID_ReadData2;
            r_se   <= ID_SignExt;
            r_rs   <= ID_Rs;
            r_rt   <= ID_Rt;
            r_rd   <= ID_Rd;
        end
        if (reset)
            r_cnt <= '0;
        else if (Stall && r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign {ID_Ex_RegWrite, ID_Ex_MemRead, ID_Ex_MemWrite, ID_Ex_MemtoReg,
            ID_Ex_ALUSrc, ID_Ex_RegDst, ID_Ex_ALUOp} = r_ctrl;
    assign ID_Ex_ReadData1 = r_rd1;
    assign ID_Ex_ReadData2 = r_rd2;
    assign ID_Ex_SignExt   = r_se;
    assign ID_Ex_Rs        = r_rs;
    assign ID_Ex_Rt        = r_rt;
    assign ID_Ex_Rd        = r_rd;
    assign BubbleCount     = r_cnt;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed vector table plus hand sequences for stall, flush, saturation and reset
module tb_id_ex_stage_reg;
    typedef struct {
        logic [7:0]  ctrl;
        logic [1:0]  uses;
        logic [31:0] rd1, rd2, se;
        logic [4:0]  rs, rt, rd;
        logic        flush;
        logic        stall;
        logic [3:0]  cnt;
    } vec_t;

    logic clk = 0, reset = 1;
    logic [7:0]  ctrl;
    logic [1:0]  uses;
    logic [31:0] rd1, rd2, se;
    logic [4:0]  rs, rt, rd;
    logic        flush;
    int errors = 0, checks = 0;

    logic        a_rw, a_mr, a_mw, a_m2r, a_src, a_dst, a_pcw, a_ifw, a_stall;
    logic [1:0]  a_op;
    logic [31:0] a_rd1, a_rd2, a_se;
    logic [4:0]  a_rs, a_rt, a_rd;
    logic [15:0] a_cnt;
    logic        s_rw, s_mr, s_mw, s_m2r, s_src, s_dst, s_pcw, s_ifw, s_stall;
    logic [1:0]  s_op;
    logic [31:0] s_rd1, s_rd2, s_se;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg u_dut (
        .clk(clk), .reset(reset),
        .ID_RegWrite(ctrl[7]), .ID_MemRead(ctrl[6]), .ID_MemWrite(ctrl[5]), .ID_MemtoReg(ctrl[4]),
        .ID_ALUSrc(ctrl[3]), .ID_RegDst(ctrl[2]), .ID_ALUOp(ctrl[1:0]),
        .ID_UsesRs(uses[1]), .ID_UsesRt(uses[0]),
        .ID_ReadData1(rd1), .ID_ReadData2(rd2), .ID_SignExt(se),
        .ID_Rs(rs), .ID_Rt(rt), .ID_Rd(rd), .ID_Flush(flush),
        .ID_Ex_RegWrite(a_rw), .ID_Ex_MemRead(a_mr), .ID_Ex_MemWrite(a_mw), .ID_Ex_MemtoReg(a_m2r),
        .ID_Ex_ALUSrc(a_src), .ID_Ex_RegDst(a_dst), .ID_Ex_ALUOp(a_op),
        .ID_Ex_ReadData1(a_rd1), .ID_Ex_ReadData2(a_rd2), .ID_Ex_SignExt(a_se),
        .ID_Ex_Rs(a_rs), .ID_Ex_Rt(a_rt), .ID_Ex_Rd(a_rd),
        .PCWrite(a_pcw), .IF_IDWrite(a_ifw), .Stall(a_stall), .BubbleCount(a_cnt)
    );

    id_ex_stage_reg #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset),
        .ID_RegWrite(ctrl[7]), .ID_MemRead(ctrl[6]), .ID_MemWrite(ctrl[5]), .ID_MemtoReg(ctrl[4]),
        .ID_ALUSrc(ctrl[3]), .ID_RegDst(ctrl[2]), .ID_ALUOp(ctrl[1:0]),
        .ID_UsesRs(uses[1]), .ID_UsesRt(uses[0]),
        .ID_ReadData1(rd1), .ID_ReadData2(rd2), .ID_SignExt(se),
        .ID_Rs(rs), .ID_Rt(rt), .ID_Rd(rd), .ID_Flush(flush),
        .ID_Ex_RegWrite(s_rw), .ID_Ex_MemRead(s_mr), .ID_Ex_MemWrite(s_mw), .ID_Ex_MemtoReg(s_m2r),
        .ID_Ex_ALUSrc(s_src), .ID_Ex_RegDst(s_dst), .ID_Ex_ALUOp(s_op),
        .ID_Ex_ReadData1(s_rd1), .ID_Ex_ReadData2(s_rd2), .ID_Ex_SignExt(s_se),
        .ID_Ex_Rs(s_rs), .ID_Ex_Rt(s_rt), .ID_Ex_Rd(s_rd),
        .PCWrite(s_pcw), .IF_IDWrite(s_ifw), .Stall(s_stall), .BubbleCount(s_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t x);
        @(negedge clk);
        ctrl = x.ctrl; uses = x.uses; rd1 = x.rd1; rd2 = x.rd2; se = x.se;
        rs = x.rs; rt = x.rt; rd = x.rd; flush = x.flush;
        #1;
    endtask

    function automatic logic [127:0] ex_fields();
        return {9'd0, a_rw, a_mr, a_mw, a_m2r, a_src, a_dst, a_op, a_rd1, a_rd2, a_se, a_rs, a_rt, a_rd};
    endfunction

    vec_t v[13];
    vec_t lw8, dep8;
    logic [127:0] exp_f;

    initial begin
        v[0]  = '{8'b1000_0010, 2'b11, 32'h1234ABCD, 32'h00005555, 32'hFFFFFFF0, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 4'd0};
        v[1]  = '{8'b1101_1000, 2'b10, 32'h00000100, 32'h0, 32'h00000004, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 4'd0};
        v[2]  = '{8'b1000_0110, 2'b11, 32'hAAAA0001, 32'hBBBB0002, 32'h0, 5'd8, 5'd9, 5'd10, 1'b0, 1'b1, 4'd1};
        v[3]  = '{8'b1000_0110, 2'b11, 32'hAAAA0001, 32'hBBBB0002, 32'h0, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0, 4'd1};
        v[4]  = '{8'b1101_1000, 2'b10, 32'h00000200, 32'h0, 32'h00000008, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 4'd1};
        v[5]  = '{8'b1000_0110, 2'b11, 32'h11111111, 32'h22222222, 32'h0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 4'd1};
        v[6]  = '{8'b1101_1000, 2'b10, 32'h00000300, 32'h0, 32'h0000000C, 5'd3, 5'd8, 5'd0, 1'b0, 1'b0, 4'd1};
        v[7]  = '{8'b1000_1000, 2'b10, 32'h00000044, 32'h00000088, 32'h00000010, 5'd4, 5'd8, 5'd0, 1'b0, 1'b0, 4'd1};
        v[8]  = '{8'b1101_1000, 2'b10, 32'h00000400, 32'h0, 32'h00000014, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0, 4'd1};
        v[9]  = '{8'b1000_0110, 2'b11, 32'hCAFEF00D, 32'h0, 32'h0, 5'd9, 5'd2, 5'd11, 1'b1, 1'b0, 4'd1};
        v[10] = '{8'b1101_1000, 2'b10, 32'h00000500, 32'h0, 32'h00000018, 5'd1, 5'd12, 5'd0, 1'b0, 1'b0, 4'd1};
        v[11] = '{8'b0010_1000, 2'b11, 32'h00000600, 32'hDEADBEEF, 32'h0000001C, 5'd3, 5'd12, 5'd0, 1'b0, 1'b1, 4'd2};
        v[12] = '{8'b0010_1000, 2'b11, 32'h00000600, 32'hDEADBEEF, 32'h0000001C, 5'd3, 5'd12, 5'd0, 1'b0, 1'b0, 4'd2};
        lw8   = '{8'b1101_1000, 2'b10, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 4'd0};
        dep8  = '{8'b1000_0110, 2'b11, 32'h5, 32'h6, 32'h0, 5'd8, 5'd8, 5'd4, 1'b0, 1'b0, 4'd0};

        // reset with busy inputs, including a would-be hazard and flush
        ctrl = 8'hFF; uses = 2'b11; rd1 = 32'hFFFFFFFF; rd2 = 32'h1; se = 32'h2;
        rs = 5'd8; rt = 5'd8; rd = 5'd8; flush = 1'b0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_fields", ex_fields(), 128'd0);
        chk("reset_cnt", {112'd0, a_cnt}, 128'd0);
        chk("reset_cnt_sat", {126'd0, s_cnt}, 128'd0);
        chk("reset_pcw_ifw_stall", {125'd0, a_pcw, a_ifw, a_stall}, {125'd0, 3'b110});
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 13; i++) begin
            step(v[i]);
            chk($sformatf("v%0d_stall", i), {127'd0, a_stall}, {127'd0, v[i].stall});
            chk($sformatf("v%0d_pcw_ifw", i), {126'd0, a_pcw, a_ifw}, {126'd0, ~v[i].stall, ~v[i].stall});
            @(posedge clk);
            #1;
            exp_f = (v[i].stall || v[i].flush) ? 128'd0 :
                    {9'd0, v[i].ctrl, v[i].rd1, v[i].rd2, v[i].se, v[i].rs, v[i].rt, v[i].rd};
            chk($sformatf("v%0d_fields", i), ex_fields(), exp_f);
            chk($sformatf("v%0d_cnt", i), {112'd0, a_cnt}, {124'd0, v[i].cnt});
            chk($sformatf("v%0d_cnt_sat", i), {126'd0, s_cnt}, {126'd0, v[i].cnt[1:0]});
        end

        // saturation on the 2-bit instance across five stall events
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            step(lw8);
            @(posedge clk);
            step(dep8);
            chk($sformatf("sat%0d_stall", i), {127'd0, s_stall}, {127'd0, 1'b1});
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d_cnt_sat", i), {126'd0, s_cnt}, (i < 3) ? 128'(i + 1) : 128'd3);
            chk($sformatf("sat%0d_cnt", i), {112'd0, a_cnt}, 128'(i + 1));
        end

        // reset asserted while a stall is pending
        step(lw8);
        @(posedge clk);
        step(dep8);
        chk("midrst_pre_stall", {127'd0, a_stall}, {127'd0, 1'b1});
        reset = 1;
        #1;
        chk("midrst_stall_gated", {126'd0, a_stall, a_pcw}, {126'd0, 2'b01});
        @(posedge clk);
        #1;
        chk("midrst_cnt", {112'd0, a_cnt}, 128'd0);
        chk("midrst_cnt_sat", {126'd0, s_cnt}, 128'd0);
        chk("midrst_memread", {126'd0, a_mr, s_mr}, 128'd0);
        @(negedge clk);
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
